vibration_monitor: RTL and testbench

VIBRATION_MONITOR -- requirements
Module: vibration_monitor

---
 rtl/vibration_monitor.sv | 171 +++++++++++++++++
 tb/tb_vibration_monitor.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vibration_monitor.sv
// rtl/vibration_monitor.sv - windowed vibration event rate meter with BCD display and blinking alarm (optional peak hold: VIB_PEAK_EN)
module vibration_monitor #(
  parameter int GATE_CYCLES  = 50_000_000,
  parameter int THRESH       = 100,
  parameter int BLINK_CYCLES = 12_500_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pulse,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_mode,
  output logic [15:0] o_data,
  output logic [3:0]  o_turn_off,
  output logic        o_alarm,
  output logic        o_busy
);

  localparam int TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(GATE_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [13:0]   BIN_MAX    = 14'd9999;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GATE  = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      sync_q;
  logic            event_det;
  logic [TW-1:0]   timer_q;
  logic [13:0]     bin_q;
  logic [15:0]     bcd_q;
  logic [31:0]     bin_ext;
  logic            start_go;
  logic            do_latch;
  logic            sat;
  logic [15:0]     rate_q;
  logic            alarm_q;
  logic [BW-1:0]   blink_cnt_q;
  logic            blink_phase_q;
  logic [15:0]     disp;
  logic [3:0]      blank;

  // Increment four packed BCD digits with ripple carry; caller guards saturation.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign event_det = sync_q[1] & ~sync_q[2];
  assign start_go  = (state_q == S_IDLE) && i_start && !i_stop;
  assign do_latch  = (state_q == S_LATCH) && !i_stop;
  assign sat       = (bin_q == BIN_MAX);
  assign bin_ext   = {18'd0, bin_q};

  // Two-flop synchroniser for the asynchronous pin plus one history flop for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) sync_q <= 3'b000;
    else       sync_q <= {sync_q[1:0], i_pulse};
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state: stop always wins, start only matters in IDLE, LATCH lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_go) state_d = S_GATE;
      S_GATE: begin
        if (i_stop)                      state_d = S_IDLE;
        else if (timer_q == TIMER_LAST)  state_d = S_LATCH;
      end
      S_LATCH: state_d = i_stop ? S_IDLE : S_GATE;
      default: state_d = S_IDLE;
    endcase
  end

  // Window timer and event counters; an event seen during LATCH seeds the next window.
  always_ff @(posedge i_clk) begin
    if (i_rst || start_go) begin
      timer_q <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
    end else if (state_q == S_GATE) begin
      timer_q <= timer_q + TW'(1);
      if (event_det && !sat) begin
        bin_q <= bin_q + 14'd1;
        bcd_q <= bcd_inc(bcd_q);
      end
    end else if (state_q == S_LATCH) begin
      timer_q <= '0;
      bin_q   <= event_det ? 14'd1 : 14'd0;
      bcd_q   <= event_det ? 16'h0001 : 16'h0000;
    end
  end

  // Rate and alarm are only updated by a completed window; stop or idle leaves them held.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rate_q  <= '0;
      alarm_q <= 1'b0;
    end else if (do_latch) begin
      rate_q  <= bcd_q;
      alarm_q <= (bin_ext >= 32'(THRESH));
    end
  end

  // Blink timer runs only while alarmed; otherwise parked at zero so each alarm starts in the on phase.
  always_ff @(posedge i_clk) begin
    if (i_rst || !alarm_q) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q   <= blink_cnt_q + BW'(1);
    end
  end

`ifdef VIB_PEAK_EN
  logic [15:0] peak_q;

  // Peak hold across windows of one run; BCD compares like the decimal value it encodes.
  always_ff @(posedge i_clk) begin
    if (i_rst || start_go)                 peak_q <= '0;
    else if (do_latch && bcd_q > peak_q)   peak_q <= bcd_q;
  end

  assign disp = i_mode ? peak_q : rate_q;
`else
  logic unused_mode;
  assign unused_mode = i_mode;
  assign disp        = rate_q;
`endif

  // Leading-zero blanking; the units digit always stays lit.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = (disp[15:12] == 4'd0);
    blank[2] = blank[3] && (disp[11:8] == 4'd0);
    blank[1] = blank[2] && (disp[7:4] == 4'd0);
  end

  assign o_data     = disp;
  assign o_turn_off = (alarm_q && blink_phase_q) ? 4'b1111 : blank;
  assign o_alarm    = alarm_q;
  assign o_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_vibration_monitor.sv
// tb/tb_vibration_monitor.sv - randomized self-checking bench for vibration_monitor (VIB_PEAK_EN selects the peak scenario)
module tb_vibration_monitor;

  localparam int G  = 100;
  localparam int TH = 5;
  localparam int B  = 10;
  localparam int G2 = 25000;

  logic        clk = 1'b0;
  logic        rst, pulse, start, stop, mode;
  logic [15:0] data;
  logic [3:0]  toff;
  logic        alarm, busy;
  logic        pulse2, start2;
  logic [15:0] data2;
  logic [3:0]  toff2;
  logic        alarm2, busy2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: events attributed to windows by cycle arithmetic.
  logic prev_p;
  bit   session;
  int   sess_start;
  int   cur_k;
  int   win_cnt [64];
  int   exp_rate_n;
  bit   exp_alarm;
  int   alarm_edge;

  always #5 clk = ~clk;

  vibration_monitor #(.GATE_CYCLES(G), .THRESH(TH), .BLINK_CYCLES(B)) dut (
    .i_clk(clk), .i_rst(rst), .i_pulse(pulse), .i_start(start), .i_stop(stop), .i_mode(mode),
    .o_data(data), .o_turn_off(toff), .o_alarm(alarm), .o_busy(busy)
  );

  vibration_monitor #(.GATE_CYCLES(G2), .THRESH(TH), .BLINK_CYCLES(B)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_pulse(pulse2), .i_start(start2), .i_stop(1'b0), .i_mode(1'b0),
    .o_data(data2), .o_turn_off(toff2), .o_alarm(alarm2), .o_busy(busy2)
  );

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [3:0] exp_toff(input int n);
    if (exp_alarm && (((cyc - alarm_edge) / B) % 2 == 1)) return 4'b1111;
    if (n < 10)   return 4'b1110;
    if (n < 100)  return 4'b1100;
    if (n < 1000) return 4'b1000;
    return 4'b0000;
  endfunction

  // Drive the pin for the next edge, record any event it creates, advance one clock.
  task automatic step(input logic p);
    if (p && !prev_p && session) begin
      int ev, k;
      ev = cyc + 2;
      k  = (ev - sess_start + 1) / (G + 1);
      if (ev >= sess_start && k < 64) win_cnt[k]++;
    end
    prev_p = p;
    pulse  = p;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_start();
    sess_start = cyc + 1;
    session    = 1'b1;
    cur_k      = 0;
    for (int k = 0; k < 64; k++) win_cnt[k] = 0;
    start = 1'b1;
    step(1'b0);
    start = 1'b0;
  endtask

  task automatic model_latch(input int k);
    exp_rate_n = (win_cnt[k] > 9999) ? 9999 : win_cnt[k];
    if (win_cnt[k] >= TH) begin
      if (!exp_alarm) alarm_edge = cyc;
      exp_alarm = 1'b1;
    end else begin
      exp_alarm = 1'b0;
    end
  endtask

  // One full window (G+1 edges) with n pulses at random slots; returns cycles whose blanking disagreed.
  task automatic run_window(input int n, input bit latch_pulse, input int start_at,
                            input bit stop_last, output int bad);
    bit sel [48];
    int need;
    need = n;
    bad  = 0;
    for (int s = 0; s < 48; s++) begin
      sel[s] = (need > 0) && ($urandom_range(47 - s, 0) < need);
      if (sel[s]) need--;
    end
    for (int j = 0; j <= G; j++) begin
      logic p;
      p = 1'b0;
      if (j < 96 && (j % 2 == 0) && sel[j / 2]) p = 1'b1;
      if (latch_pulse && j == G - 2) p = 1'b1;
      start = (j == start_at);
      stop  = stop_last && (j == G);
      step(p);
      start = 1'b0;
      stop  = 1'b0;
      if (j == G) begin
        if (stop_last) session = 1'b0;
        else           model_latch(cur_k);
      end
      if (toff !== exp_toff(exp_rate_n)) bad++;
    end
    cur_k++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b0);
    step(1'b0);
    n_checks++; if (data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", data); end
    n_checks++; if (toff !== 4'b1110) begin n_fail++; $display("FAIL reset_turn_off: got %b expected 1110", toff); end
    n_checks++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL reset_alarm: got %b expected 0", alarm); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    exp_rate_n = 0;
    exp_alarm  = 1'b0;
    step(1'b0);
  endtask

  task automatic test_normal();
    int bad;
    do_start();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b expected 1", busy); end
    run_window(3, 1'b0, -1, 1'b0, bad);
    n_checks++; if (data !== 16'h0003) begin n_fail++; $display("FAIL normal_data: got %h expected 0003", data); end
    n_checks++; if (toff !== 4'b1110 || bad !== 0) begin n_fail++; $display("FAIL normal_turn_off: got %b (%0d bad cycles) expected 1110", toff, bad); end
    n_checks++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL normal_alarm: got %b expected 0", alarm); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL normal_busy: got %b expected 1", busy); end
  endtask

  task automatic test_alarm();
    int bad;
    run_window(7, 1'b0, -1, 1'b0, bad);
    n_checks++; if (alarm !== 1'b1) begin n_fail++; $display("FAIL alarm_set: got %b expected 1", alarm); end
    n_checks++; if (data !== 16'h0007) begin n_fail++; $display("FAIL alarm_data: got %h expected 0007", data); end
    run_window(2, 1'b0, -1, 1'b0, bad);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL alarm_blink: got %0d bad cycles expected 0", bad); end
    n_checks++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL alarm_clear: got %b expected 0", alarm); end
    run_window($urandom_range(4, 0), 1'b0, -1, 1'b0, bad);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL alarm_steady: got %0d bad cycles expected 0", bad); end
    n_checks++; if (data !== to_bcd(exp_rate_n)) begin n_fail++; $display("FAIL alarm_next_data: got %h expected %h", data, to_bcd(exp_rate_n)); end
  endtask

  task automatic test_blanking();
    int bad;
    run_window(42, 1'b0, -1, 1'b0, bad);
    n_checks++; if (data !== 16'h0042) begin n_fail++; $display("FAIL blank42_data: got %h expected 0042", data); end
    n_checks++; if (toff !== exp_toff(42)) begin n_fail++; $display("FAIL blank42_turn_off: got %b expected %b", toff, exp_toff(42)); end
    for (int i = 0; i < 4; i++) begin
      run_window($urandom_range(48, 0), 1'($urandom_range(1, 0)), -1, 1'b0, bad);
      n_checks++; if (data !== to_bcd(exp_rate_n)) begin n_fail++; $display("FAIL random_data[%0d]: got %h expected %h", i, data, to_bcd(exp_rate_n)); end
      n_checks++; if (alarm !== exp_alarm) begin n_fail++; $display("FAIL random_alarm[%0d]: got %b expected %b", i, alarm, exp_alarm); end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL random_turn_off[%0d]: got %0d bad cycles expected 0", i, bad); end
    end
  endtask

  task automatic test_latch_edge();
    int bad;
    run_window(4, 1'b1, -1, 1'b0, bad);
    n_checks++; if (data !== 16'h0004) begin n_fail++; $display("FAIL latch_edge_first: got %h expected 0004", data); end
    run_window(3, 1'b0, -1, 1'b0, bad);
    n_checks++; if (data !== 16'h0004) begin n_fail++; $display("FAIL latch_edge_carry: got %h expected 0004", data); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL latch_edge_turn_off: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_start_stop();
    int          bad;
    logic [15:0] held;
    run_window($urandom_range(30, 6), 1'b0, 50, 1'b0, bad);
    n_checks++; if (data !== to_bcd(exp_rate_n)) begin n_fail++; $display("FAIL start_in_gate_data: got %h expected %h", data, to_bcd(exp_rate_n)); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL start_in_gate_turn_off: got %0d bad cycles expected 0", bad); end
    for (int j = 0; j < 30; j++) step(j == 4 || j == 10);
    held  = to_bcd(exp_rate_n);
    start = 1'b1;
    stop  = 1'b1;
    step(1'b0);
    start   = 1'b0;
    stop    = 1'b0;
    session = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_stop_busy: got %b expected 0", busy); end
    n_checks++; if (data !== held) begin n_fail++; $display("FAIL start_stop_data: got %h expected %h", data, held); end
    for (int j = 0; j < 20; j++) step(j % 4 == 0);
    n_checks++; if (data !== held || busy !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got %h busy %b expected %h busy 0", data, busy, held); end
    do_start();
    run_window($urandom_range(30, 6), 1'b0, -1, 1'b1, bad);
    n_checks++; if (data !== held) begin n_fail++; $display("FAIL stop_in_latch_data: got %h expected %h", data, held); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_in_latch_busy: got %b expected 0", busy); end
    n_checks++; if (alarm !== exp_alarm) begin n_fail++; $display("FAIL stop_in_latch_alarm: got %b expected %b", alarm, exp_alarm); end
  endtask

  task automatic test_mode();
    int bad;
`ifdef VIB_PEAK_EN
    do_start();
    run_window(4, 1'b0, -1, 1'b0, bad);
    run_window(9, 1'b0, -1, 1'b0, bad);
    run_window(2, 1'b0, -1, 1'b0, bad);
    mode = 1'b1;
    #1;
    n_checks++; if (data !== 16'h0009) begin n_fail++; $display("FAIL peak_data: got %h expected 0009", data); end
    n_checks++; if (toff !== 4'b1110) begin n_fail++; $display("FAIL peak_turn_off: got %b expected 1110", toff); end
    stop = 1'b1;
    step(1'b0);
    stop    = 1'b0;
    session = 1'b0;
    do_start();
    n_checks++; if (data !== 16'h0000) begin n_fail++; $display("FAIL peak_cleared: got %h expected 0000", data); end
    mode = 1'b0;
    stop = 1'b1;
    step(1'b0);
    stop    = 1'b0;
    session = 1'b0;
`else
    bad  = 0;
    mode = 1'b1;
    #1;
    n_checks++; if (data !== to_bcd(exp_rate_n) || bad !== 0) begin n_fail++; $display("FAIL mode_ignored: got %h expected %h", data, to_bcd(exp_rate_n)); end
    mode = 1'b0;
    step(1'b0);
`endif
  endtask

  task automatic test_reset_mid();
    do_start();
    for (int j = 0; j < 40; j++) step(1'($urandom_range(1, 0)));
    rst = 1'b1;
    step(1'b0);
    session    = 1'b0;
    exp_rate_n = 0;
    exp_alarm  = 1'b0;
    n_checks++; if (data !== 16'h0000) begin n_fail++; $display("FAIL reset_mid_data: got %h expected 0000", data); end
    n_checks++; if (busy !== 1'b0 || alarm !== 1'b0) begin n_fail++; $display("FAIL reset_mid_flags: got busy %b alarm %b expected 0 0", busy, alarm); end
    n_checks++; if (toff !== 4'b1110) begin n_fail++; $display("FAIL reset_mid_turn_off: got %b expected 1110", toff); end
    rst = 1'b0;
    step(1'b0);
  endtask

  task automatic test_saturation();
    int n2, e2;
    n2     = 0;
    start2 = 1'b1;
    step(1'b0);
    start2 = 1'b0;
    for (int j = 0; j <= G2; j++) begin
      pulse2 = (j % 2 == 0);
      if (pulse2 && j <= G2 - 3) n2++;
      step(1'b0);
    end
    pulse2 = 1'b0;
    e2 = (n2 > 9999) ? 9999 : n2;
    n_checks++; if (data2 !== to_bcd(e2)) begin n_fail++; $display("FAIL sat_data: got %h expected %h", data2, to_bcd(e2)); end
    n_checks++; if (toff2 !== 4'b0000) begin n_fail++; $display("FAIL sat_turn_off: got %b expected 0000", toff2); end
    n_checks++; if (alarm2 !== 1'b1 || busy2 !== 1'b1) begin n_fail++; $display("FAIL sat_flags: got alarm %b busy %b expected 1 1", alarm2, busy2); end
  endtask

  initial begin
    rst = 1'b1; pulse = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
    pulse2 = 1'b0; start2 = 1'b0;
    prev_p = 1'b0; session = 1'b0; sess_start = 0; cur_k = 0;
    exp_rate_n = 0; exp_alarm = 1'b0; alarm_edge = 0;
    for (int k = 0; k < 64; k++) win_cnt[k] = 0;
    test_reset();
    test_normal();
    test_alarm();
    test_blanking();
    test_latch_edge();
    test_start_stop();
    test_mode();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
